fetch_decode_stage: RTL and testbench

- Instruction fetch plus IF/ID pipeline register for the 32-bit single-issue CPU.
- Owns the PC and issues requests to instruction memory.
- Registers each returned instruction and splits it into decode fields.
- id_imm16 drives the sign-extension stage directly; register-index and control fields go to the register file and control unit.
- Supports stall (hold) and redirect (branch/jump flush) from downstream.

---
 rtl/fetch_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_fetch_decode_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Instruction fetch (PC owner) and IF/ID pipeline register with decode field split.
// Define IMEM_WAIT_EN for multi-cycle instruction memory (ack handshake plus one-entry pending buffer).
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
`ifdef IMEM_WAIT_EN
    localparam logic [1:0] S_WAIT  = 2'd2;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        ld_en;
    logic [31:0] ld_instr;
    logic [31:0] ld_pc;

`ifdef IMEM_WAIT_EN
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_instr_q, pend_instr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    // Set when a redirect abandons an outstanding request whose ack is still to come.
    logic        drop_q, drop_d;
`else
    logic        unused_ack;
    assign unused_ack = imem_ack;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        imem_req      = 1'b0;
        ld_en         = 1'b0;
        ld_instr      = imem_rdata;
        ld_pc         = pc_q;
`ifdef IMEM_WAIT_EN
        pend_vld_d    = pend_vld_q;
        pend_instr_d  = pend_instr_q;
        pend_pc_d     = pend_pc_q;
        drop_d        = drop_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect_i) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
`ifdef IMEM_WAIT_EN
                imem_req = !stall_i && !redirect_i && !pend_vld_q && !drop_q;
                if (drop_q && imem_ack) begin
                    drop_d = 1'b0;
                end
                if (redirect_i) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    pend_vld_d = 1'b0;
                end else if (!stall_i) begin
                    // A buffered word always drains before any new request goes out.
                    if (pend_vld_q) begin
                        ld_en      = 1'b1;
                        ld_instr   = pend_instr_q;
                        ld_pc      = pend_pc_q;
                        pend_vld_d = 1'b0;
                    end else if (imem_req) begin
                        if (imem_ack) begin
                            ld_en = 1'b1;
                            pc_d  = pc_q + PC_STEP;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
`else
                imem_req = !stall_i && !redirect_i;
                if (redirect_i) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                end else if (!stall_i) begin
                    ld_en = 1'b1;
                    pc_d  = pc_q + PC_STEP;
                end
`endif
            end
`ifdef IMEM_WAIT_EN
            S_WAIT: begin
                // Request and address stay up until the memory acks, regardless of stall.
                imem_req = 1'b1;
                if (redirect_i) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    pend_vld_d = 1'b0;
                    drop_d     = !imem_ack;
                    state_d    = S_FETCH;
                end else if (imem_ack) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_FETCH;
                    if (stall_i) begin
                        pend_vld_d   = 1'b1;
                        pend_instr_d = imem_rdata;
                        pend_pc_d    = pc_q;
                    end else begin
                        ld_en = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        if (ld_en) begin
            id_valid_d    = 1'b1;
            id_instr_d    = ld_instr;
            id_pc_d       = ld_pc;
            id_pc_plus4_d = ld_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
`ifdef IMEM_WAIT_EN
            pend_vld_q    <= 1'b0;
            drop_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
`ifdef IMEM_WAIT_EN
            pend_vld_q    <= pend_vld_d;
            drop_q        <= drop_d;
`endif
        end
    end

`ifdef IMEM_WAIT_EN
    // Payload is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_instr_q <= pend_instr_d;
        pend_pc_q    <= pend_pc_d;
    end
`endif

    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_opcode   = id_instr_q[31:26];
    assign id_rs       = id_instr_q[25:21];
    assign id_rt       = id_instr_q[20:16];
    assign id_rd       = id_instr_q[15:11];
    assign id_shamt    = id_instr_q[10:6];
    assign id_funct    = id_instr_q[5:0];
    assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: memory returns word = address unless overridden.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_i, imem_ack, ovr;
    logic [31:0] redirect_pc, ovr_word;
    int          checks = 0;
    int          errors = 0;

    logic        req_a, req_b, vld_a, vld_b;
    logic [31:0] addr_a, addr_b, rdata_a, rdata_b;
    logic [31:0] instr_a, instr_b, pc_a, pc_b, pc4_a, pc4_b;
    logic [5:0]  op_a, op_b, fn_a, fn_b;
    logic [4:0]  rs_a, rs_b, rt_a, rt_b, rd_a, rd_b, sh_a, sh_b;
    logic [15:0] imm_a, imm_b;

    assign rdata_a = ovr ? ovr_word : addr_a;
    assign rdata_b = addr_b;

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(imem_ack), .imem_rdata(rdata_a), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc(redirect_pc), .id_valid(vld_a),
        .id_instr(instr_a), .id_pc(pc_a), .id_pc_plus4(pc4_a), .id_opcode(op_a),
        .id_rs(rs_a), .id_rt(rt_a), .id_rd(rd_a), .id_shamt(sh_a),
        .id_funct(fn_a), .id_imm16(imm_a)
    );

    fetch_decode_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(imem_ack), .imem_rdata(rdata_b), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc(redirect_pc), .id_valid(vld_b),
        .id_instr(instr_b), .id_pc(pc_b), .id_pc_plus4(pc4_b), .id_opcode(op_b),
        .id_rs(rs_b), .id_rt(rt_b), .id_rd(rd_b), .id_shamt(sh_b),
        .id_funct(fn_b), .id_imm16(imm_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; imem_ack = 1'b0;
        ovr = 1'b0; ovr_word = 32'h8C22_FFF0; redirect_pc = 32'h0;
        tick(); tick();
        chk("rst_valid", {31'd0, vld_a}, 32'd0);
        chk("rst_id_pc", pc_a, 32'd0);
        chk("rst_instr", instr_a, 32'd0);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_addr_wrap", addr_b, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        #1;
        chk("idle_req", {31'd0, req_a}, 32'd0);
`ifdef IMEM_WAIT_EN
        tick(); #1;
        chk("w_req_issue", {31'd0, req_a}, 32'd1);
        chk("w_addr_issue", addr_a, 32'd0);
        tick(); #1;
        chk("w_req_wait", {31'd0, req_a}, 32'd1);
        chk("w_addr_wait", addr_a, 32'd0);
        tick();
        stall_i = 1'b1; imem_ack = 1'b1;
        #1;
        chk("w_req_ack", {31'd0, req_a}, 32'd1);
        chk("w_addr_ack", addr_a, 32'd0);
        tick();
        imem_ack = 1'b0;
        #1;
        chk("w_buf_valid", {31'd0, vld_a}, 32'd0);
        chk("w_buf_req", {31'd0, req_a}, 32'd0);
        tick();
        stall_i = 1'b0;
        #1;
        chk("w_drain_req", {31'd0, req_a}, 32'd0);
        tick(); #1;
        chk("w_rel_valid", {31'd0, vld_a}, 32'd1);
        chk("w_rel_pc", pc_a, 32'd0);
        chk("w_rel_pc4", pc4_a, 32'd4);
        chk("w_next_req", {31'd0, req_a}, 32'd1);
        chk("w_next_addr", addr_a, 32'd4);
        tick(); #1;
        chk("w_wait2_addr", addr_a, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("w_mrst_valid", {31'd0, vld_a}, 32'd0);
        chk("w_mrst_pc", pc_a, 32'd0);
        chk("w_mrst_instr", instr_a, 32'd0);
        chk("w_mrst_req", {31'd0, req_a}, 32'd0);
        chk("w_mrst_addr", addr_a, 32'd0);
`else
        tick(); #1;
        chk("first_req", {31'd0, req_a}, 32'd1);
        chk("first_valid", {31'd0, vld_a}, 32'd0);
        tick(); #1;
        chk("c2_valid", {31'd0, vld_a}, 32'd1);
        chk("c2_pc", pc_a, 32'h0);
        chk("c2_instr", instr_a, 32'h0);
        chk("c2_pc_wrap", pc_b, 32'hFFFF_FFF8);
        tick(); #1;
        chk("c3_pc", pc_a, 32'h4);
        chk("c3_instr", instr_a, 32'h4);
        chk("c3_pc_wrap", pc_b, 32'hFFFF_FFFC);
        tick();
        stall_i = 1'b1;
        #1;
        chk("c4_pc", pc_a, 32'h8);
        chk("c4_pc_wrap", pc_b, 32'h0000_0000);
        chk("c4_pc4_wrap", pc4_b, 32'h0000_0004);
        chk("stall_req", {31'd0, req_a}, 32'd0);
        chk("stall_addr", addr_a, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("stall_pc", pc_a, 32'h8);
            chk("stall_valid", {31'd0, vld_a}, 32'd1);
        end
        stall_i = 1'b0;
        #1;
        chk("unstall_req", {31'd0, req_a}, 32'd1);
        tick();
        ovr = 1'b1;
        #1;
        chk("after_stall_pc", pc_a, 32'hC);
        tick();
        ovr = 1'b0; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("dec_instr", instr_a, 32'h8C22_FFF0);
        chk("dec_opcode", {26'd0, op_a}, 32'h23);
        chk("dec_rs", {27'd0, rs_a}, 32'd1);
        chk("dec_rt", {27'd0, rt_a}, 32'd2);
        chk("dec_rd", {27'd0, rd_a}, 32'd31);
        chk("dec_shamt", {27'd0, sh_a}, 32'd31);
        chk("dec_funct", {26'd0, fn_a}, 32'h30);
        chk("dec_imm16", {16'd0, imm_a}, 32'hFFF0);
        chk("dec_pc", pc_a, 32'h10);
        chk("dec_pc4", pc4_a, 32'h14);
        chk("redir_req", {31'd0, req_a}, 32'd0);
        tick();
        stall_i = 1'b0; redirect_i = 1'b0;
        #1;
        chk("redir_valid", {31'd0, vld_a}, 32'd0);
        chk("redir_addr", addr_a, 32'h100);
        tick(); #1;
        chk("redir_pc", pc_a, 32'h100);
        chk("redir_instr", instr_a, 32'h100);
        chk("redir_vld1", {31'd0, vld_a}, 32'd1);
        tick(); #1;
        chk("redir_pc_next", pc_a, 32'h104);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, vld_a}, 32'd0);
        chk("mrst_pc", pc_a, 32'd0);
        chk("mrst_instr", instr_a, 32'd0);
        chk("mrst_req", {31'd0, req_a}, 32'd0);
        chk("mrst_addr", addr_a, 32'd0);
        chk("mrst_addr_wrap", addr_b, 32'hFFFF_FFF8);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
